// File: rtl/line_buffer_pkg.sv
// Shared defaults and types for the 3-row line buffer that feeds the Convolution stage.
package line_buffer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;
  localparam int COL_W_DEF  = $clog2(IMG_W_DEF);
  localparam int ROW_W_DEF  = $clog2(IMG_H_DEF);

  typedef logic [DATA_W_DEF-1:0] pixel_t;

endpackage

// File: rtl/line_buffer_3row_if.sv
// Pixel-in / column-out bundle of the line buffer. Producer drives i_*, the buffer drives o_*.
// No backpressure: every cycle with i_valid=1 is a consumed pixel; o_valid marks a column for one cycle.
interface line_buffer_3row_if
  import line_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COL_W  = COL_W_DEF
);

  logic              i_valid;
  logic              i_sof;
  logic [DATA_W-1:0] i_pixel;
  logic              o_valid;
  logic [DATA_W-1:0] o_x1;
  logic [DATA_W-1:0] o_x2;
  logic [DATA_W-1:0] o_x3;
  logic [COL_W-1:0]  o_col;
  logic              o_eol;
  logic              o_eof;

  modport master (
    output i_valid, i_sof, i_pixel,
    input  o_valid, o_x1, o_x2, o_x3, o_col, o_eol, o_eof
  );

  modport slave (
    input  i_valid, i_sof, i_pixel,
    output o_valid, o_x1, o_x2, o_x3, o_col, o_eol, o_eof
  );

endinterface

// File: rtl/line_buffer_3row_line_mem.sv
// One image line of storage: synchronous write, asynchronous read of the same address,
// so a read in the write cycle returns the old contents (read-before-write).
module line_mem
  import line_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = IMG_W_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Deliberately unreset: stale contents are masked by the row counter upstream.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/line_buffer_3row.sv
// Raster pixel stream in, vertical 3-pixel column (rows r-2, r-1, r) out, one cycle later.
// Optional macro LINE_BUFFER_ZERO_PAD_EN: emit rows 0/1 too, with the missing rows forced to 0.
module line_buffer_3row
  import line_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF
) (
  input  logic               clk,
  input  logic               rst,
  line_buffer_3row_if.slave  bus
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              valid_q, valid_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;
  logic [DATA_W-1:0] x1_q, x1_d;
  logic [DATA_W-1:0] x2_q, x2_d;
  logic [DATA_W-1:0] x3_q, x3_d;
  logic [COL_W-1:0]  ocol_q, ocol_d;

  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic              row_ge1;
  logic              row_ge2;
  logic              is_eol;
  logic              mem_we;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;

  // mem0 holds line r-1, mem1 holds line r-2; a write shifts the column down one line.
  line_mem #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_mem0 (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cur_col),
    .wdata (bus.i_pixel),
    .rdata (rd0)
  );

  line_mem #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(COL_W)) u_mem1 (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cur_col),
    .wdata (rd0),
    .rdata (rd1)
  );

  always_comb begin
    // i_sof overrides the counters so the pixel lands at (0,0) whatever came before.
    cur_col = bus.i_sof ? '0 : col_q;
    cur_row = bus.i_sof ? '0 : row_q;
    row_ge1 = (cur_row != '0);
    row_ge2 = row_ge1 && (cur_row != ROW_W'(1));
    is_eol  = (cur_col == COL_LAST);

    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    eol_d   = 1'b0;
    eof_d   = 1'b0;
    x1_d    = x1_q;
    x2_d    = x2_q;
    x3_d    = x3_q;
    ocol_d  = ocol_q;
    mem_we  = 1'b0;

    if (bus.i_valid && !rst) begin
      mem_we = 1'b1;
`ifdef LINE_BUFFER_ZERO_PAD_EN
      valid_d = 1'b1;
      x1_d    = row_ge2 ? rd1 : '0;
      x2_d    = row_ge1 ? rd0 : '0;
`else
      valid_d = row_ge2;
      x1_d    = rd1;
      x2_d    = rd0;
`endif
      x3_d    = bus.i_pixel;
      ocol_d  = cur_col;
      eol_d   = valid_d && is_eol;
      eof_d   = valid_d && is_eol && (cur_row == ROW_LAST);

      if (is_eol) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      x1_q    <= '0;
      x2_q    <= '0;
      x3_q    <= '0;
      ocol_q  <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      x3_q    <= x3_d;
      ocol_q  <= ocol_d;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_x1    = x1_q;
  assign bus.o_x2    = x2_q;
  assign bus.o_x3    = x3_q;
  assign bus.o_col   = ocol_q;
  assign bus.o_eol   = eol_q;
  assign bus.o_eof   = eof_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row on a 4x4 image: a table-driven frame, hand sequences, then random traffic.
module tb_line_buffer_3row;
  import line_buffer_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_buffer_3row_if #(.DATA_W(8), .COL_W(2)) bus ();

  line_buffer_3row #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic       valid;
    pixel_t     x1;
    pixel_t     x2;
    pixel_t     x3;
    logic [1:0] col;
    logic       eol;
    logic       eof;
    logic       x_known;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   m_last;
  int     m_r;
  int     m_c;
  pixel_t m_img[H][W];

  // Column output is simply the current frame's pixels straight above (r-2, r-1) and the new one.
  task automatic model(input logic r, input logic v, input logic s, input pixel_t p);
    exp_t e;
    e = '0;
    if (r) begin
      m_r = 0;
      m_c = 0;
      e.x_known = 1'b1;
    end else if (v) begin
      if (s) begin
        m_r = 0;
        m_c = 0;
      end
      m_img[m_r][m_c] = p;
`ifdef LINE_BUFFER_ZERO_PAD_EN
      e.valid = 1'b1;
`else
      e.valid = (m_r >= 2);
`endif
      if (m_r >= 2) e.x1 = m_img[m_r-2][m_c];
      if (m_r >= 1) e.x2 = m_img[m_r-1][m_c];
      e.x3      = p;
      e.col     = m_c[1:0];
      e.eol     = e.valid && (m_c == W-1);
      e.eof     = e.valid && (m_c == W-1) && (m_r == H-1);
      e.x_known = e.valid;
      m_c++;
      if (m_c == W) begin
        m_c = 0;
        m_r = (m_r + 1) % H;
      end
    end else begin
      e       = m_last;
      e.valid = 1'b0;
      e.eol   = 1'b0;
      e.eof   = 1'b0;
    end
    m_last = e;
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".valid"}, 32'(bus.o_valid), 32'(e.valid));
    chk({tag, ".eol"},   32'(bus.o_eol),   32'(e.eol));
    chk({tag, ".eof"},   32'(bus.o_eof),   32'(e.eof));
    if (e.x_known) begin
      chk({tag, ".x1"},  32'(bus.o_x1),  32'(e.x1));
      chk({tag, ".x2"},  32'(bus.o_x2),  32'(e.x2));
      chk({tag, ".x3"},  32'(bus.o_x3),  32'(e.x3));
      chk({tag, ".col"}, 32'(bus.o_col), 32'(e.col));
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic v, input logic s, input pixel_t p, input string tag);
    rst         = r;
    bus.i_valid = v;
    bus.i_sof   = s;
    bus.i_pixel = p;
    model(r, v, s, p);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic stream_pixel(input int r, input int c, input int base, input logic s, input string tag);
    drive(1'b0, 1'b1, s, pixel_t'(base + 10*r + c), tag);
  endtask

  // ---------------- table-driven frame ----------------
  typedef struct {
    logic       v;
    logic       s;
    pixel_t     p;
    logic       ev;
    pixel_t     e1;
    pixel_t     e2;
    pixel_t     e3;
    logic [1:0] ecol;
    logic       eeol;
    logic       eeof;
    logic       xchk;
  } vec_t;

  vec_t tbl[W*H];

  initial begin
    int r;
    int c;

    for (int i = 0; i < W*H; i++) begin
      r = i / W;
      c = i % W;
      tbl[i].v    = 1'b1;
      tbl[i].s    = (i == 0);
      tbl[i].p    = pixel_t'(10*r + c);
`ifdef LINE_BUFFER_ZERO_PAD_EN
      tbl[i].ev   = 1'b1;
`else
      tbl[i].ev   = (r >= 2);
`endif
      tbl[i].e1   = (r >= 2) ? pixel_t'(10*(r-2) + c) : 8'd0;
      tbl[i].e2   = (r >= 1) ? pixel_t'(10*(r-1) + c) : 8'd0;
      tbl[i].e3   = pixel_t'(10*r + c);
      tbl[i].ecol = 2'(c);
      tbl[i].eeol = tbl[i].ev && (c == W-1);
      tbl[i].eeof = tbl[i].ev && (c == W-1) && (r == H-1);
      tbl[i].xchk = tbl[i].ev;
    end

    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_pixel = '0;

    drive(1'b1, 1'b0, 1'b0, 8'd0, "reset0");
    drive(1'b1, 1'b1, 1'b0, 8'd77, "reset_with_valid");

    rst = 1'b0;
    for (int i = 0; i < W*H; i++) begin
      bus.i_valid = tbl[i].v;
      bus.i_sof   = tbl[i].s;
      bus.i_pixel = tbl[i].p;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.valid", i), 32'(bus.o_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d.eol", i),   32'(bus.o_eol),   32'(tbl[i].eeol));
      chk($sformatf("tbl%0d.eof", i),   32'(bus.o_eof),   32'(tbl[i].eeof));
      if (tbl[i].xchk) begin
        chk($sformatf("tbl%0d.x1", i),  32'(bus.o_x1),  32'(tbl[i].e1));
        chk($sformatf("tbl%0d.x2", i),  32'(bus.o_x2),  32'(tbl[i].e2));
        chk($sformatf("tbl%0d.x3", i),  32'(bus.o_x3),  32'(tbl[i].e3));
        chk($sformatf("tbl%0d.col", i), 32'(bus.o_col), 32'(tbl[i].ecol));
      end
    end

    // Model takes over from here; reset it together with the DUT.
    drive(1'b1, 1'b0, 1'b0, 8'd0, "reset1");

    // Idle gaps inside row 2 must not disturb the columns; i_sof without i_valid is ignored.
    for (int rr = 0; rr < H; rr++) begin
      for (int cc = 0; cc < W; cc++) begin
        stream_pixel(rr, cc, 0, (rr == 0 && cc == 0), "gap_px");
        if (rr == 2) begin
          repeat ($urandom_range(1, 3)) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), "gap_idle");
        end
      end
    end

    // Reset mid-frame after pixel 22, then restart without i_sof: no stale column may appear.
    for (int i = 0; i < 11; i++) stream_pixel(i / W, i % W, 0, (i == 0), "pre_rst");
    drive(1'b1, 1'b0, 1'b0, 8'd0, "mid_rst");
    for (int i = 0; i < W*H; i++) stream_pixel(i / W, i % W, 100, 1'b0, "post_rst");

    // i_sof at row 3 col 2 abandons the frame; new frame rows 2..3 use only new data.
    for (int i = 0; i < 14; i++) stream_pixel(i / W, i % W, 0, (i == 0), "pre_sof");
    for (int i = 0; i < W*H; i++) stream_pixel(i / W, i % W, 120, (i == 0), "post_sof");

    // Reset coinciding with a valid pixel drops that pixel.
    for (int i = 0; i < 9; i++) stream_pixel(i / W, i % W, 50, (i == 0), "pre_rstv");
    drive(1'b1, 1'b1, 1'b0, 8'd200, "rst_and_valid");
    for (int i = 0; i < W*H; i++) stream_pixel(i / W, i % W, 60, 1'b0, "post_rstv");

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 29) == 0),
            8'($urandom),
            "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
